// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one LSB-first shift-add multiplier among N requesters.
// One partial product per cycle; the tagged result is held until the consumer accepts it.
module mult_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8,
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [2*W-1:0]   rsp_data,
    output logic             busy
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned PW = 2 * W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state;
    logic [1:0]     next_state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   a_sh;
    logic [PW-1:0]  b_sh;
    logic [PW-1:0]  acc;
    logic [PW-1:0]  acc_next;

    logic [N-1:0]   rot;
    logic [IDW:0]   sum;
    logic [IDW-1:0] grant;
    logic           any_valid;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic           accept;
    logic           last;

    // First valid requester at or after ptr, found via a rotated copy of req_valid.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        sum       = '0;
        rot       = N'({req_valid, req_valid} >> ptr);
        for (int k = 0; k < N; k++) begin
            if (!any_valid && rot[k]) begin
                any_valid = 1'b1;
                sum       = {1'b0, ptr} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(N)) begin
                    sum = sum - (IDW+1)'(N);
                end
                grant = sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == IDW'(i)) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    assign accept    = (state == IDLE) && any_valid && !rst;
    assign req_ready = accept ? (N'(1) << grant) : '0;
    assign last      = (cnt == CW'(W - 1));
    assign acc_next  = a_sh[0] ? (acc + b_sh) : acc;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (last) next_state = DONE;
            DONE:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, shift-add iteration, result latch and pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            id       <= '0;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh <= a_sel;
                        b_sh <= {{W{1'b0}}, b_sel};
                        acc  <= '0;
                        id   <= grant;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh << 1;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        rsp_data <= acc_next;
                        rsp_id   <= id;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        ptr <= (id == IDW'(N - 1)) ? '0 : id + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one shift-add multiply engine (one partial product per cycle, LSB-first) among N requesters. Round-robin arbitration, per-requester valid/ready operand ports, single tagged response port with backpressure. Sits between client blocks needing occasional unsigned products and the multiplier datapath. It replaces N free-running multipliers with one start-controlled engine.

## Interface
- N, default 4: number of requesters, 2..8.
- W, default 8: operand width; product is 2W bits.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N  requester i presents operands.
- req_ready  out  N  one-hot grant/accept; at most one bit set.
- req_a  in  N*W  operand A, requester i at bits [i*W +: W] (multiplier, consumed LSB-first).
- req_b  in  N*W  operand B, requester i at bits [i*W +: W] (multiplicand, shifted left).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  $clog2(N) (min 1)  index of requester that owns rsp_data.
- rsp_data  out  2W  unsigned product A*B.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: grant = first i with req_valid[i], searching ptr, ptr+1, … mod N. req_ready = onehot(grant) combinationally when any valid, else 0. On handshake (req_valid[g] & req_ready[g]): capture a_sh=req_a[g], b_sh={W'0, req_b[g]}, acc=0, id=g, cnt=0; go RUN.
- req_ready is 0 in RUN and DONE; requests wait, no queuing.
- RUN, each cycle: if a_sh[0], acc <= acc + b_sh; a_sh <= a_sh>>1; b_sh <= b_sh<<1; cnt++. When cnt==W-1, go DONE. Fixed W iterations, no early exit on a_sh==0.
- Arithmetic: acc and b_sh are 2W bits; A*B ≤ (2^W-1)^2 < 2^(2W), so no overflow and no truncation. acc is monotonically non-decreasing during RUN.
- DONE: rsp_valid=1, rsp_data=acc, rsp_id=id, all stable until rsp_ready. On rsp_valid&rsp_ready: ptr <= (id+1) mod N, go IDLE.
- Rsp handshake cycle never also accepts a request; next accept is earliest the following cycle.
- rsp_data/rsp_id hold last value outside DONE but are only meaningful while rsp_valid.
- Requester dropping req_valid while not granted: allowed, no effect. Operands changing after handshake: no effect on the in-flight product.
- Reset (any time, including mid-RUN or DONE with rsp_ready low): state IDLE, ptr=0, acc=0, cnt=0, id=0; in-flight result discarded, no rsp_valid emitted.

## Timing
- Reset values: req_ready=0 while rst high, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- Accept at edge T → RUN cycles T+1..T+W → rsp_valid high from cycle T+W+1 (T+9 for W=8).
- Back-to-back with rsp_ready tied high: one result per W+2 cycles (10 for W=8).
- Fairness: with all N requesters continuously valid, grants rotate 0,1,…,N-1,0; each waits at most (N-1)(W+2) cycles after first becoming eligible.
- Pointer wrap: id=N-1 completes → ptr=0.
- req_ready depends combinationally on req_valid; no combinational path from rsp_ready to req_ready within the same cycle (state-gated).

## Test plan
- Single request, N=4, W=8: req 2 with A=255, B=255 accepted at T → rsp_valid at T+9, rsp_data=65025, rsp_id=2, busy high T+1..T+9.
- Zero/identity: A=0,B=200 → 0; A=1,B=200 → 200; A=200,B=1 → 200; A=0xAA,B=0x55 → 14450; each exactly 9 cycles after accept.
- Round-robin: all four valid continuously, distinct operands, rsp_ready=1 → rsp_id sequence 0,1,2,3,0; accepts spaced 10 cycles; each product correct.
- Backpressure: rsp_ready low 5 cycles in DONE → rsp_valid, rsp_data, rsp_id stable, req_ready all 0 with requesters waiting; after rsp_ready, next grant the cycle after the rsp handshake.
- Reset mid-run: assert rst at RUN cycle 4 (asynchronously, mid-cycle) → outputs immediately at reset values, no rsp_valid for that request, ptr=0 so requester 0 wins next if valid.
- Pointer skip: only requesters 1 and 3 valid, ptr=0 → grant 1 then 3 then 1; rsp_ids match.
